// File: rtl/uart_pkg.sv
// Shared constants for the uart_tx arbiter: FSM state encoding and byte width.
package uart_pkg;

  localparam int BYTE_W = 8;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_START = 2'd1;
  localparam state_t ST_WAIT  = 2'd2;

endpackage

// File: rtl/uart_rr_pick.sv
// Combinational round-robin picker: first valid bit at or above ptr, wrapping modulo N.
module uart_rr_pick #(
  parameter int N  = 4,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  valid,
  input  logic [IW-1:0] ptr,
  output logic          any,
  output logic [IW-1:0] idx,
  output logic [N-1:0]  onehot
);

  localparam int DW = $clog2(2 * N);

  logic [2*N-1:0] dbl_valid;
  logic           hit;
  logic [DW-1:0]  hit_pos;

  // Scanning the doubled vector from ptr upward turns the wrap into a plain priority search.
  assign dbl_valid = {valid, valid};

  always_comb begin
    hit     = 1'b0;
    hit_pos = '0;
    for (int k = 0; k < N; k++) begin
      if (!hit && dbl_valid[DW'(int'(ptr) + k)]) begin
        hit     = 1'b1;
        hit_pos = DW'(int'(ptr) + k);
      end
    end
  end

  assign any = hit;

  always_comb begin
    if (hit_pos >= DW'(N)) begin
      idx = IW'(hit_pos - DW'(N));
    end else begin
      idx = IW'(hit_pos);
    end
  end

  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_onehot
      assign onehot[gi] = hit && (idx == IW'(gi));
    end
  endgenerate

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one uart_tx core among N_REQ byte-stream requesters,
// with an optional burst lock of up to LOCK_MAX bytes per grant.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int N_REQ    = 4,
  parameter int LOCK_MAX = 4
) (
  input  logic                    HCLK,
  input  logic                    HRESET,
  input  logic                    en,
  input  logic [N_REQ-1:0]        req_valid,
  input  logic [BYTE_W*N_REQ-1:0] req_data,
  input  logic [N_REQ-1:0]        req_last,
  output logic [N_REQ-1:0]        req_ready,
  output logic [N_REQ-1:0]        grant,
  output logic                    busy,
  output logic                    tx_start,
  output logic [BYTE_W-1:0]       tx_data,
  input  logic                    tx_done
);

  localparam int IW = $clog2(N_REQ);
  localparam int CW = $clog2(LOCK_MAX + 1);

  state_t            state_reg, state_next;
  logic [IW-1:0]     rr_ptr_reg;
  logic [IW-1:0]     owner_reg;
  logic [CW-1:0]     cnt_reg;
  logic              last_reg;
  logic [BYTE_W-1:0] tx_data_reg;
  logic [N_REQ-1:0]  grant_reg;

  logic [BYTE_W-1:0] req_byte [N_REQ];
  logic              pick_any;
  logic [IW-1:0]     pick_idx;
  logic [N_REQ-1:0]  pick_onehot;
  logic              accept;
  logic              cont;
  logic              release_now;

  generate
    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_bytes
      assign req_byte[gi] = req_data[BYTE_W*gi +: BYTE_W];
    end
  endgenerate

  uart_rr_pick #(
    .N  (N_REQ),
    .IW (IW)
  ) u_pick (
    .valid  (req_valid),
    .ptr    (rr_ptr_reg),
    .any    (pick_any),
    .idx    (pick_idx),
    .onehot (pick_onehot)
  );

  // Gating with HRESET keeps ready low while reset holds the FSM in IDLE.
  assign accept = (state_reg == ST_IDLE) && en && pick_any && !HRESET;

  assign cont = (state_reg == ST_WAIT) && tx_done && !last_reg &&
                (cnt_reg < CW'(LOCK_MAX)) && en && req_valid[owner_reg];

  assign release_now = (state_reg == ST_WAIT) && tx_done && !cont;

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE:  if (accept) state_next = ST_START;
      ST_START: state_next = ST_WAIT;
      ST_WAIT: begin
        if (cont) begin
          state_next = ST_START;
        end else if (release_now) begin
          state_next = ST_IDLE;
        end
      end
      default:  state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    req_ready = '0;
    if (accept) begin
      req_ready = pick_onehot;
    end else if (cont) begin
      req_ready = grant_reg;
    end
    busy     = (state_reg != ST_IDLE);
    tx_start = (state_reg == ST_START);
  end

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      rr_ptr_reg  <= '0;
      owner_reg   <= '0;
      cnt_reg     <= '0;
      last_reg    <= 1'b0;
      tx_data_reg <= '0;
      grant_reg   <= '0;
    end else if (accept) begin
      tx_data_reg <= req_byte[pick_idx];
      grant_reg   <= pick_onehot;
      owner_reg   <= pick_idx;
      cnt_reg     <= CW'(1);
      last_reg    <= req_last[pick_idx];
    end else if (cont) begin
      tx_data_reg <= req_byte[owner_reg];
      cnt_reg     <= cnt_reg + CW'(1);
      last_reg    <= req_last[owner_reg];
    end else if (release_now) begin
      grant_reg  <= '0;
      rr_ptr_reg <= (owner_reg == IW'(N_REQ - 1)) ? '0 : owner_reg + IW'(1);
    end
  end

  assign grant   = grant_reg;
  assign tx_data = tx_data_reg;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench: two arbiters (LOCK_MAX=4 and LOCK_MAX=1) with a scoreboard of expected starts.
module tb_uart_tx_arbiter;

  logic       HCLK = 1'b0;
  logic       HRESET;
  logic       en        [2];
  logic [3:0] req_valid [2];
  logic [31:0] req_data [2];
  logic [3:0] req_last  [2];
  logic [3:0] req_ready [2];
  logic [3:0] grant     [2];
  logic       busy      [2];
  logic       tx_start  [2];
  logic [7:0] tx_data   [2];
  logic       tx_done   [2];

  always #5 HCLK = ~HCLK;

  uart_tx_arbiter #(.N_REQ(4), .LOCK_MAX(4)) dut (
    .HCLK(HCLK), .HRESET(HRESET), .en(en[0]),
    .req_valid(req_valid[0]), .req_data(req_data[0]), .req_last(req_last[0]),
    .req_ready(req_ready[0]), .grant(grant[0]), .busy(busy[0]),
    .tx_start(tx_start[0]), .tx_data(tx_data[0]), .tx_done(tx_done[0])
  );

  uart_tx_arbiter #(.N_REQ(4), .LOCK_MAX(1)) dut_rr (
    .HCLK(HCLK), .HRESET(HRESET), .en(en[1]),
    .req_valid(req_valid[1]), .req_data(req_data[1]), .req_last(req_last[1]),
    .req_ready(req_ready[1]), .grant(grant[1]), .busy(busy[1]),
    .tx_start(tx_start[1]), .tx_data(tx_data[1]), .tx_done(tx_done[1])
  );

  logic [8:0]  src_q [8][$];
  logic [11:0] exp_q [2][$];
  int          core_cnt   [2];
  logic        prev_start [2];
  logic [7:0]  start_data [2];
  logic [3:0]  smp_ready  [2];
  logic [3:0]  smp_grant  [2];
  logic        smp_start  [2];
  logic [3:0]  hs         [2];
  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive();
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < 4; i++) begin
        logic [8:0] e;
        int q;
        q = d * 4 + i;
        if (src_q[q].size() != 0) begin
          e = src_q[q][0];
          req_valid[d][i]      = 1'b1;
          req_data[d][8*i +: 8] = e[7:0];
          req_last[d][i]       = e[8];
        end else begin
          req_valid[d][i]      = 1'b0;
          req_data[d][8*i +: 8] = 8'h00;
          req_last[d][i]       = 1'b0;
        end
      end
    end
  endtask

  task automatic push(input int d, input int i, input logic [7:0] data, input logic last);
    src_q[d*4+i].push_back({last, data});
    drive();
  endtask

  task automatic sb_expect(input int d, input int i, input logic [7:0] data);
    exp_q[d].push_back({4'(1 << i), data});
  endtask

  // One clock: sample and check at the falling edge, advance sources and the core model after the rising edge.
  task automatic cycle();
    logic [11:0] e;
    @(negedge HCLK);
    for (int d = 0; d < 2; d++) begin
      smp_ready[d] = req_ready[d];
      smp_grant[d] = grant[d];
      smp_start[d] = tx_start[d];
      hs[d]        = req_valid[d] & req_ready[d];
      chk("ready_onehot", 32'($onehot0(req_ready[d])), 1);
      chk("grant_onehot", 32'($onehot0(grant[d])), 1);
      chk("start_not_repeated", 32'(tx_start[d] && prev_start[d]), 0);
      chk("ready_when_allowed", 32'((|req_ready[d]) && busy[d] && !tx_done[d]), 0);
      if (tx_done[d] && busy[d]) chk("tx_data_stable", tx_data[d], start_data[d]);
      if (tx_start[d]) begin
        n_tests++;
        assert (exp_q[d].size() != 0) else begin
          n_fail++;
          $error("FAIL sb_unexpected_start dut%0d observed data=%0h expected no start", d, tx_data[d]);
        end
        if (exp_q[d].size() != 0) begin
          e = exp_q[d].pop_front();
          chk("sb_grant", grant[d], e[11:8]);
          chk("sb_data", tx_data[d], e[7:0]);
        end
        $display("[TB] dut%0d start grant=%b data=%h", d, grant[d], tx_data[d]);
        start_data[d] = tx_data[d];
        core_cnt[d]   = 3;
      end
      prev_start[d] = tx_start[d];
    end
    @(posedge HCLK);
    #1;
    for (int d = 0; d < 2; d++) begin
      if (!HRESET) begin
        for (int i = 0; i < 4; i++) begin
          if (hs[d][i]) void'(src_q[d*4+i].pop_front());
        end
      end
      tx_done[d] = 1'b0;
      if (core_cnt[d] > 0) begin
        core_cnt[d]--;
        if (core_cnt[d] == 0) tx_done[d] = 1'b1;
      end
    end
    drive();
  endtask

  function automatic bit srcs_empty(input int d);
    bit r = 1'b1;
    for (int i = 0; i < 4; i++) if (src_q[d*4+i].size() != 0) r = 1'b0;
    return r;
  endfunction

  task automatic wait_idle(input int d, input int budget);
    bit ok = 1'b0;
    for (int k = 0; k < budget && !ok; k++) begin
      cycle();
      ok = (exp_q[d].size() == 0) && !busy[d] && (core_cnt[d] == 0) && srcs_empty(d);
    end
    n_tests++;
    assert (ok) else begin
      n_fail++;
      $error("FAIL wait_idle dut%0d observed pending=%0d expected 0 within %0d cycles",
             d, exp_q[d].size(), budget);
    end
  endtask

  initial begin
    int starts;
    bit got;
    HRESET = 1'b1;
    for (int d = 0; d < 2; d++) begin
      en[d] = 1'b1; tx_done[d] = 1'b0; core_cnt[d] = 0;
      prev_start[d] = 1'b0; start_data[d] = 8'h00;
    end
    drive();
    repeat (2) @(posedge HCLK);
    #1;
    chk("rst_ready", req_ready[0], 0);
    chk("rst_grant", grant[0], 0);
    chk("rst_busy", busy[0], 0);
    chk("rst_start", tx_start[0], 0);
    chk("rst_data", tx_data[0], 0);
    chk("rst_grant_rr", grant[1], 0);
    HRESET = 1'b0;

    // Single requester: req 1 sends 0x41.
    push(0, 1, 8'h41, 1'b1);
    sb_expect(0, 1, 8'h41);
    cycle();
    chk("t1_ready", smp_ready[0], 4'b0010);
    chk("t1_no_start_yet", smp_start[0], 0);
    cycle();
    chk("t1_start", smp_start[0], 1);
    chk("t1_grant", smp_grant[0], 4'b0010);
    chk("t1_ready_clear", smp_ready[0], 0);
    wait_idle(0, 50);
    chk("t1_grant_released", grant[0], 0);

    // Fairness with LOCK_MAX=1: all four continuously valid.
    for (int k = 0; k < 2; k++)
      for (int i = 0; i < 4; i++) push(1, i, 8'(16 * i + k), 1'b0);
    for (int k = 0; k < 2; k++)
      for (int i = 0; i < 4; i++) sb_expect(1, i, 8'(16 * i + k));
    wait_idle(1, 200);

    // Burst lock: req2 message of three bytes stays contiguous ahead of req0.
    push(0, 2, 8'hA0, 1'b0);
    push(0, 2, 8'hA1, 1'b0);
    push(0, 2, 8'hA2, 1'b1);
    push(0, 0, 8'hB0, 1'b1);
    sb_expect(0, 2, 8'hA0);
    sb_expect(0, 2, 8'hA1);
    sb_expect(0, 2, 8'hA2);
    sb_expect(0, 0, 8'hB0);
    wait_idle(0, 100);

    // Lock cap: req1 sends six bytes with no last, req3 gets in after four.
    for (int k = 0; k < 6; k++) push(0, 1, 8'(8'hC0 + k), 1'b0);
    push(0, 3, 8'hD0, 1'b1);
    for (int k = 0; k < 4; k++) sb_expect(0, 1, 8'(8'hC0 + k));
    sb_expect(0, 3, 8'hD0);
    sb_expect(0, 1, 8'hC4);
    sb_expect(0, 1, 8'hC5);
    wait_idle(0, 150);

    // Enable drop while 0x55 is in flight.
    push(0, 2, 8'h55, 1'b0);
    push(0, 2, 8'h56, 1'b1);
    push(0, 0, 8'h66, 1'b1);
    push(0, 3, 8'h77, 1'b1);
    sb_expect(0, 2, 8'h55);
    sb_expect(0, 3, 8'h77);
    sb_expect(0, 0, 8'h66);
    sb_expect(0, 2, 8'h56);
    cycle();
    cycle();
    chk("t5_first_start", smp_start[0], 1);
    en[0] = 1'b0;
    starts = 0;
    repeat (10) begin
      cycle();
      if (smp_start[0]) starts++;
    end
    chk("t5_no_start_while_disabled", starts, 0);
    chk("t5_byte_completed", busy[0], 0);
    en[0] = 1'b1;
    got = 1'b0;
    repeat (2) begin
      cycle();
      if (smp_start[0]) got = 1'b1;
    end
    chk("t5_start_after_enable", got, 1);
    wait_idle(0, 100);

    // Reset in WAIT with another request pending.
    push(0, 1, 8'h99, 1'b1);
    sb_expect(0, 1, 8'h99);
    cycle();
    cycle();
    cycle();
    push(0, 2, 8'h9A, 1'b1);
    #2;
    HRESET = 1'b1;
    #1;
    chk("t6_ready", req_ready[0], 0);
    chk("t6_grant", grant[0], 0);
    chk("t6_busy", busy[0], 0);
    chk("t6_start", tx_start[0], 0);
    chk("t6_data", tx_data[0], 0);
    for (int i = 0; i < 4; i++) src_q[i].delete();
    core_cnt[0] = 0;
    tx_done[0]  = 1'b0;
    drive();
    cycle();
    HRESET = 1'b0;
    tx_done[0] = 1'b1;
    cycle();
    chk("t6_stray_ready", smp_ready[0], 0);
    cycle();
    chk("t6_stray_start", smp_start[0], 0);
    chk("t6_stray_busy", busy[0], 0);
    push(0, 3, 8'hE3, 1'b1);
    push(0, 0, 8'hE0, 1'b1);
    sb_expect(0, 0, 8'hE0);
    sb_expect(0, 3, 8'hE3);
    wait_idle(0, 60);

    chk("end_sb_empty0", exp_q[0].size(), 0);
    chk("end_sb_empty1", exp_q[1].size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
